regfile_sb: RTL and testbench

//  Parametrised register file for the MIPS datapath: 2 registered read ports, 1 write port,

---
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port, an optional
// hardwired zero register, optional write-to-read bypass, and a scoreboard.
// The scoreboard keeps one busy bit per register and a count of busy registers,
// so decode can detect RAW hazards against writes that have not landed yet.
//
// Handshake semantics: there is no backpressure anywhere in this block.
//   - writeBack is a single-cycle strobe; every edge that sees it high commits
//     din to rd and retires the outstanding write of rd.
//   - issue is a single-cycle strobe; every edge that sees it high marks
//     issue_rd as having an outstanding write.
//   - rd_en qualifies the read ports; with rd_en low, regA/regB/busyA/busyB hold.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              rd_en,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regB,
  output logic              busyA,
  output logic              busyB,
  input  logic              writeBack,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] din,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  logic              rd_is_zero;
  logic              rs_is_zero;
  logic              rt_is_zero;
  logic              ird_is_zero;
  logic              wr_en;
  logic              iss_en;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  // Address-0 qualifiers; they collapse to 0 when there is no zero register.
  always_comb begin
    rd_is_zero  = (ZERO_REG != 0) && (rd == '0);
    rs_is_zero  = (ZERO_REG != 0) && (rs == '0);
    rt_is_zero  = (ZERO_REG != 0) && (rt == '0);
    ird_is_zero = (ZERO_REG != 0) && (issue_rd == '0);
    wr_en       = writeBack && !rd_is_zero;
    iss_en      = issue && !ird_is_zero;
  end

  // Next scoreboard state: retire first, then issue, so a same-address issue wins.
  always_comb begin
    busy_next = busy;
    if (writeBack) busy_next[rd] = 1'b0;
    if (iss_en)    busy_next[issue_rd] = 1'b1;
  end

  // Count deltas: only a real 0->1 or 1->0 transition of some bit moves the count.
  always_comb begin
    cnt_inc = iss_en && !busy[issue_rd];
    cnt_dec = writeBack && busy[rd] && !(iss_en && (issue_rd == rd));
  end

  // Read data selection: zero register, then same-cycle bypass, then storage.
  always_comb begin
    rdata_a = regs[rs];
    rdata_b = regs[rt];
    if ((BYPASS != 0) && wr_en && (rd == rs)) rdata_a = din;
    if ((BYPASS != 0) && wr_en && (rd == rt)) rdata_b = din;
    if (rs_is_zero) rdata_a = '0;
    if (rt_is_zero) rdata_b = '0;
  end

  // Register storage; address 0 is never written when it is hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= din;
    end
  end

  // Scoreboard bits and busy-register count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_next;
      pending_cnt <= pending_cnt + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
    end
  end

  // Registered read ports; busy flags use the post-update state to line up with data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regA  <= '0;
      regB  <= '0;
      busyA <= 1'b0;
      busyB <= 1'b0;
    end else if (rd_en) begin
      regA  <= rdata_a;
      regB  <= rdata_b;
      busyA <= busy_next[rs];
      busyB <= busy_next[rt];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two instances share stimulus, one with bypass and
// one without, both with the hardwired zero register. A behavioural model
// (plain arrays and a popcount) predicts every output.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] rs = '0, rt = '0, rd = '0, issue_rd = '0;
  logic          rd_en = 1'b0, writeBack = 1'b0, issue = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] regA, regB, regA_nb, regB_nb;
  logic          busyA, busyB, busyA_nb, busyB_nb;
  logic [AW:0]   pending_cnt, pending_cnt_nb;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd_en(rd_en),
    .regA(regA), .regB(regB), .busyA(busyA), .busyB(busyB),
    .writeBack(writeBack), .rd(rd), .din(din),
    .issue(issue), .issue_rd(issue_rd), .pending_cnt(pending_cnt)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd_en(rd_en),
    .regA(regA_nb), .regB(regB_nb), .busyA(busyA_nb), .busyB(busyB_nb),
    .writeBack(writeBack), .rd(rd), .din(din),
    .issue(issue), .issue_rd(issue_rd), .pending_cnt(pending_cnt_nb)
  );

  // ---------------- scoreboard / model ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic cmp_en = 1'b0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] exp_a, exp_b, exp_a_nb, exp_b_nb;
  logic          exp_busy_a, exp_busy_b;
  logic [AW:0]   exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    exp_a = '0; exp_b = '0; exp_a_nb = '0; exp_b_nb = '0;
    exp_busy_a = 1'b0; exp_busy_b = 1'b0; exp_cnt = '0;
  endtask

  // Value a read port returns: register 0 is zero, bypass shows the write in flight.
  function automatic logic [DW-1:0] read_val(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && writeBack && rd == a) return din;
    return m_mem[a];
  endfunction

  // Advance the model by one clock edge, using the inputs held across that edge.
  task automatic model_edge();
    int n;
    if (rd_en) begin
      exp_a    = read_val(rs, 1'b1);
      exp_b    = read_val(rt, 1'b1);
      exp_a_nb = read_val(rs, 1'b0);
      exp_b_nb = read_val(rt, 1'b0);
    end
    if (writeBack && rd != 0) m_mem[rd] = din;
    if (writeBack) m_busy[rd] = 1'b0;
    if (issue && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (rd_en) begin
      exp_busy_a = m_busy[rs];
      exp_busy_b = m_busy[rt];
    end
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    exp_cnt = n[AW:0];
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic wb_i, input logic [AW-1:0] rd_i, input logic [DW-1:0] din_i,
                      input logic is_i, input logic [AW-1:0] ird_i,
                      input logic re_i, input logic [AW-1:0] rs_i, input logic [AW-1:0] rt_i);
    writeBack = wb_i; rd = rd_i; din = din_i;
    issue = is_i; issue_rd = ird_i;
    rd_en = re_i; rs = rs_i; rt = rt_i;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, rs, rt);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_regA", 64'(regA), 64'd0);
    check("rst_regB", 64'(regB), 64'd0);
    check("rst_busyA", 64'(busyA), 64'd0);
    check("rst_busyB", 64'(busyB), 64'd0);
    check("rst_cnt", 64'(pending_cnt), 64'd0);
    check("rst_nb_regA", 64'(regA_nb), 64'd0);
    rst = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("regA", 64'(regA), 64'(exp_a));
      check("regB", 64'(regB), 64'(exp_b));
      check("busyA", 64'(busyA), 64'(exp_busy_a));
      check("busyB", 64'(busyB), 64'(exp_busy_b));
      check("pending_cnt", 64'(pending_cnt), 64'(exp_cnt));
      check("nb_regA", 64'(regA_nb), 64'(exp_a_nb));
      check("nb_regB", 64'(regB_nb), 64'(exp_b_nb));
      check("nb_busyA", 64'(busyA_nb), 64'(exp_busy_a));
      check("nb_busyB", 64'(busyB_nb), 64'(exp_busy_b));
      check("nb_pending_cnt", 64'(pending_cnt_nb), 64'(exp_cnt));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    model_reset();
    #12;
    check("init_regA", 64'(regA), 64'd0);
    check("init_cnt", 64'(pending_cnt), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // write then read back
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd5, 5'd0);
    check("lit_write_read", 64'(regA), 64'h0000_0000_DEAD_BEEF);

    // same-cycle write and read: bypass versus no bypass
    step(1'b1, 5'd7, 32'h1234, 1'b0, '0, 1'b1, 5'd7, 5'd7);
    check("lit_bypass_A", 64'(regA), 64'h1234);
    check("lit_bypass_B", 64'(regB), 64'h1234);
    check("lit_nobypass_A", 64'(regA_nb), 64'h0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd7, 5'd7);
    check("lit_nobypass_next", 64'(regA_nb), 64'h1234);

    // zero register ignores write and issue
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    check("lit_zero_regA", 64'(regA), 64'h0);
    check("lit_zero_busyA", 64'(busyA), 64'h0);
    check("lit_zero_cnt", 64'(pending_cnt), 64'h0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd0, 5'd0);
    check("lit_zero_reread", 64'(regA), 64'h0);

    // scoreboard counting
    step(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd4, 1'b1, 5'd3, 5'd4);
    check("lit_cnt2", 64'(pending_cnt), 64'd2);
    check("lit_busy3", 64'(busyA), 64'd1);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b1, 5'd3, 5'd4);
    check("lit_reissue_busy", 64'(busyA), 64'd1);
    check("lit_reissue_cnt", 64'(pending_cnt), 64'd2);
    step(1'b1, 5'd4, 32'h44, 1'b0, '0, 1'b1, 5'd4, 5'd3);
    check("lit_wb4_cnt", 64'(pending_cnt), 64'd1);
    check("lit_wb4_busyA", 64'(busyA), 64'd0);
    check("lit_wb4_busyB", 64'(busyB), 64'd1);

    // rd_en low holds the read ports while the register changes underneath
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd9, 5'd9);
    step(1'b1, 5'd9, 32'hAA55, 1'b0, '0, 1'b0, 5'd9, 5'd9);
    check("lit_hold_regA", 64'(regA), 64'h0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd9, 5'd9);
    check("lit_hold_release", 64'(regA), 64'hAA55);

    // directed mid-run reset with the scoreboard non-empty
    step(1'b0, '0, '0, 1'b1, 5'd6, 1'b1, 5'd6, 5'd5);
    async_reset();

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom(),
           1'($urandom_range(0, 1)), rand_addr(),
           1'($urandom_range(0, 3) != 0), rand_addr(), rand_addr());
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    // fill the scoreboard completely to reach the maximum count
    for (int i = 1; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(i), '0);
    check("lit_full_cnt", 64'(pending_cnt), 64'(DEPTH - 1));

    idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
